// File: rtl/avalon_pkg.sv
// Shared types and widths for the Avalon-MM RAM responder.
package avalon_pkg;

   typedef enum logic {
      READY = 1'b0,
      BUSY  = 1'b1
   } avalon_state_t;

   localparam int AVALON_DATA_W = 32;
   localparam int AVALON_BE_W   = 4;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11; loads seed on reset, steps every cycle.
module lfsr16 (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] seed,
   output logic [15:0] out
);

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= seed;
      else       lfsr_q <= lfsr_d;
   end

   assign out = lfsr_q;

endmodule

// File: rtl/avalon_bus_ram.sv
// Avalon-MM word RAM responder with byte-lane writes and a programmable waitrequest stall.
// Define AVALON_BUS_RAM_RANDOM_WAIT_EN to add 0-3 pseudo-random extra stall cycles.
module avalon_bus_ram
   import avalon_pkg::*;
#(
   parameter int          ADDR_W      = 10,
   parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
   parameter int          WAIT_CYCLES = 1,
   parameter string       INIT_FILE   = "",
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        write,
   input  logic        read,
   output logic        waitrequest,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata
);

   localparam int CNT_W = $clog2(WAIT_CYCLES + 4) + 1;
   localparam logic [CNT_W-1:0] WAIT_LEN = CNT_W'(WAIT_CYCLES);

   logic [AVALON_DATA_W-1:0] mem [2**ADDR_W];

   avalon_state_t    state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [31:0]      readdata_q, readdata_d;
   logic [CNT_W-1:0] stall_len;
   logic             accept;
   logic [31:0]      offset;
   logic             in_range;
   logic [ADDR_W-1:0] idx;

`ifdef AVALON_BUS_RAM_RANDOM_WAIT_EN
   logic [15:0] lfsr;
   wire         unused_lfsr = &{1'b0, lfsr[15:2]};

   lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (SEED),
      .out   (lfsr)
   );

   assign stall_len = WAIT_LEN + CNT_W'(lfsr[1:0]);
`else
   wire [15:0] unused_seed = SEED;

   assign stall_len = WAIT_LEN;
`endif

   // Unsigned wrap below BASE_ADDR lands far out of range, so one compare covers both sides.
   assign offset   = address - BASE_ADDR;
   assign in_range = (offset[31:ADDR_W+2] == '0);
   assign idx      = offset[ADDR_W+1:2];
   wire unused_off = &{1'b0, offset[1:0]};

   assign accept = (state_q == READY) && (read || write);

   always_comb begin
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      readdata_d  = readdata_q;
      case (state_q)
         READY: begin
            if (accept && stall_len != '0) begin
               state_d     = BUSY;
               stall_cnt_d = stall_len;
            end
         end
         BUSY: begin
            stall_cnt_d = stall_cnt_q - 1'b1;
            if (stall_cnt_q == CNT_W'(1)) state_d = READY;
         end
         default: state_d = READY;
      endcase
      if (accept && read && !write) readdata_d = in_range ? mem[idx] : 32'h0000_0000;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= READY;
         stall_cnt_q <= '0;
         readdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         readdata_q  <= readdata_d;
      end
   end

   // Memory has no reset so images survive a CPU reset.
   always_ff @(posedge clk) begin
      if (!reset && accept && write && in_range) begin
         for (int b = 0; b < AVALON_BE_W; b++) begin
            if (byteenable[b]) mem[idx][8*b +: 8] <= writedata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && accept && read && write)
         $error("avalon_bus_ram: read and write asserted together; write performed");
   end

   assign waitrequest = (state_q == BUSY);
   assign readdata    = readdata_q;

endmodule

// File: tb/tb_avalon_bus_ram.sv
// Directed bench for avalon_bus_ram: three instances with WAIT_CYCLES 1, 0 and 5.
module tb_avalon_bus_ram;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   [3];
   logic [31:0] addr  [3];
   logic        wr    [3];
   logic        rd    [3];
   logic [31:0] wdata [3];
   logic [3:0]  be    [3];
   logic        wreq  [3];
   logic [31:0] rdata [3];

   int total = 0;
   int bad   = 0;

   avalon_bus_ram #(.WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .reset(rst[0]), .address(addr[0]), .write(wr[0]), .read(rd[0]),
      .waitrequest(wreq[0]), .writedata(wdata[0]), .byteenable(be[0]), .readdata(rdata[0]));

   avalon_bus_ram #(.WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .reset(rst[1]), .address(addr[1]), .write(wr[1]), .read(rd[1]),
      .waitrequest(wreq[1]), .writedata(wdata[1]), .byteenable(be[1]), .readdata(rdata[1]));

   avalon_bus_ram #(.WAIT_CYCLES(5)) u_w5 (
      .clk(clk), .reset(rst[2]), .address(addr[2]), .write(wr[2]), .read(rd[2]),
      .waitrequest(wreq[2]), .writedata(wdata[2]), .byteenable(be[2]), .readdata(rdata[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Call at a negedge; returns at a negedge with waitrequest low.
   task automatic xfer(input int d, input bit is_wr, input logic [31:0] a, input logic [31:0] dat,
                       input logic [3:0] b, output logic [31:0] rdv, output int stall);
      int n = 0;
      addr[d] = a; wdata[d] = dat; be[d] = b; wr[d] = is_wr; rd[d] = !is_wr;
      while (wreq[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++; bad++;
         $display("FAIL accept_timeout dut%0d: waited %0d cycles", d, n);
      end
      @(posedge clk);
      #1;
      rdv = rdata[d];
      wr[d] = 1'b0; rd[d] = 1'b0;
      stall = 0;
      @(negedge clk);
      while (wreq[d] && stall < 50) begin
         stall++;
         @(negedge clk);
      end
   endtask

   typedef struct {
      bit          is_wr;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl [18];

   initial begin
      logic [31:0] rdv;
      int          st;

      tbl[0]  = '{1'b1, 32'hBFC0_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000};
      tbl[1]  = '{1'b0, 32'hBFC0_0010, 32'h0,         4'h0, 32'hDEAD_BEEF};
      tbl[2]  = '{1'b1, 32'hBFC0_0020, 32'h1122_3344, 4'hF, 32'hDEAD_BEEF};
      tbl[3]  = '{1'b1, 32'hBFC0_0020, 32'hAABB_CCDD, 4'h5, 32'hDEAD_BEEF};
      tbl[4]  = '{1'b0, 32'hBFC0_0022, 32'h0,         4'hF, 32'h11BB_33DD};
      tbl[5]  = '{1'b1, 32'hBFC0_0000, 32'h1234_5678, 4'hF, 32'h11BB_33DD};
      tbl[6]  = '{1'b1, 32'h0000_0000, 32'h5555_5555, 4'hF, 32'h11BB_33DD};
      tbl[7]  = '{1'b1, 32'hBFC0_1000, 32'h5555_5555, 4'hF, 32'h11BB_33DD};
      tbl[8]  = '{1'b1, 32'hBFBF_FFFC, 32'h5555_5555, 4'hF, 32'h11BB_33DD};
      tbl[9]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0000};
      tbl[10] = '{1'b0, 32'hBFC0_1000, 32'h0,         4'h0, 32'h0000_0000};
      tbl[11] = '{1'b0, 32'hBFC0_0000, 32'h0,         4'h0, 32'h1234_5678};
      tbl[12] = '{1'b0, 32'hBFC0_0010, 32'h0,         4'h0, 32'hDEAD_BEEF};
      tbl[13] = '{1'b1, 32'hBFC0_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF};
      tbl[14] = '{1'b0, 32'hBFC0_0013, 32'h0,         4'h0, 32'hDEAD_BEEF};
      tbl[15] = '{1'b1, 32'hBFC0_0FFC, 32'h0BAD_F00D, 4'hF, 32'hDEAD_BEEF};
      tbl[16] = '{1'b0, 32'hBFC0_0FFC, 32'h0,         4'h0, 32'h0BAD_F00D};
      tbl[17] = '{1'b0, 32'hBFC0_0020, 32'h0,         4'h0, 32'h11BB_33DD};

      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; addr[d] = '0; wr[d] = 1'b0; rd[d] = 1'b0; wdata[d] = '0; be[d] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check($sformatf("reset_wait_dut%0d", d), 32'(wreq[d]), 32'h0);
         check($sformatf("reset_rdata_dut%0d", d), rdata[d], 32'h0);
      end

      // WAIT_CYCLES=1 table
      for (int i = 0; i < 18; i++) begin
         xfer(0, tbl[i].is_wr, tbl[i].a, tbl[i].d, tbl[i].be, rdv, st);
         check($sformatf("w1_rdata_v%0d", i), rdv, tbl[i].exp_rd);
         check($sformatf("w1_stall_v%0d", i), 32'(st), 32'd1);
      end

      // WAIT_CYCLES=0: preload words 0-3, read them back-to-back
      for (int i = 0; i < 4; i++) begin
         xfer(1, 1'b1, 32'hBFC0_0000 + 32'(4 * i), 32'hC0DE_0000 | 32'(i), 4'hF, rdv, st);
         check($sformatf("w0_wr_stall%0d", i), 32'(st), 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
         xfer(1, 1'b0, 32'hBFC0_0000 + 32'(4 * i), 32'h0, 4'h0, rdv, st);
         check($sformatf("w0_rd_data%0d", i), rdv, 32'hC0DE_0000 | 32'(i));
         check($sformatf("w0_rd_stall%0d", i), 32'(st), 32'd0);
      end
      // Write immediately followed by read on the next edge
      xfer(1, 1'b1, 32'hBFC0_0014, 32'h0F0F_A5A5, 4'hF, rdv, st);
      xfer(1, 1'b0, 32'hBFC0_0014, 32'h0, 4'h0, rdv, st);
      check("w0_wr_then_rd", rdv, 32'h0F0F_A5A5);

      // WAIT_CYCLES=5: reset two cycles into a stall, with a write held across the reset edge
      xfer(2, 1'b1, 32'hBFC0_0040, 32'h600D_CAFE, 4'hF, rdv, st);
      check("w5_wr_stall", 32'(st), 32'd5);
      addr[2] = 32'hBFC0_0040; rd[2] = 1'b1;
      @(posedge clk);
      #1;
      rd[2] = 1'b0;
      check("w5_rd_data", rdata[2], 32'h600D_CAFE);
      check("w5_busy_after_accept", 32'(wreq[2]), 32'h1);
      @(posedge clk);
      @(negedge clk);
      rst[2] = 1'b1; wr[2] = 1'b1; wdata[2] = 32'hFFFF_FFFF; be[2] = 4'hF;
      @(posedge clk);
      #1;
      check("w5_reset_wait", 32'(wreq[2]), 32'h0);
      check("w5_reset_rdata", rdata[2], 32'h0);
      @(negedge clk);
      rst[2] = 1'b0; wr[2] = 1'b0;
      xfer(2, 1'b0, 32'hBFC0_0040, 32'h0, 4'h0, rdv, st);
      check("w5_mem_kept", rdv, 32'h600D_CAFE);
      check("w5_rd_stall", 32'(st), 32'd5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
